hit_frame_encoder: RTL and testbench



---
 rtl/hit_frame_encoder_if.sv | 29 ++
 rtl/hit_frame_encoder.sv | 172 +++++++++++++++++
 tb/tb_hit_frame_encoder.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_frame_encoder_if.sv
// Frame-encoder port bundle: row loading, frame control and the fiber/lane outputs.
interface hit_frame_encoder_if #(
  parameter int unsigned NCOL  = 38,
  parameter int unsigned NLANE = 16
);
  logic                  start;
  logic [9:0]            frame_id;
  logic                  row_valid;
  logic                  row_ready;
  logic [5:0]            row_y;
  logic [NCOL-1:0]       row_bits;
  logic                  row_last;
  logic [15:0]           fiber;
  logic [16*NLANE-1:0]   fxch;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [8:0]            hit_count;

  modport master (
    output start, frame_id, row_valid, row_y, row_bits, row_last,
    input  row_ready, fiber, fxch, busy, done, overflow, hit_count
  );

  modport slave (
    input  start, frame_id, row_valid, row_y, row_bits, row_last,
    output row_ready, fiber, fxch, busy, done, overflow, hit_count
  );
endinterface

// File: rtl/hit_frame_encoder.sv
// Collects a hit bitmap row by row, extracts set bits into coordinate words and
// serialises them as header / 16 data cycles / trailer on the fiber link.
module hit_frame_encoder #(
  parameter int unsigned NROW  = 38,
  parameter int unsigned NCOL  = 38,
  parameter int unsigned NLANE = 16,
  parameter int unsigned NSLOT = 16
) (
  input logic               clk,
  input logic               rst,
  hit_frame_encoder_if.slave bus
);
  localparam int unsigned CAP   = NLANE * NSLOT;
  localparam int unsigned LaneW = $clog2(NLANE);
  localparam int unsigned SlotW = $clog2(NSLOT);
  localparam int unsigned BufW  = LaneW + SlotW;

  typedef enum logic [2:0] {StIdle, StLoad, StScan, StHdr, StData, StTrail, StGap} state_e;

  state_e              state_q, state_d;
  logic [NCOL-1:0]     map_q [NROW];
  logic [12:0]         buf_q [CAP];
  logic [9:0]          fid_q;
  logic [5:0]          row_q, row_d;
  logic [SlotW-1:0]    slot_q, slot_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                row_ready_q, busy_q, done_q;
  logic [15:0]         fiber_q, fiber_d;
  logic [16*NLANE-1:0] fxch_q, fxch_d;

  logic                start_acc, load_hs, scan_hit, remain;
  logic [NCOL-1:0]     cur_row, hit_mask;
  logic [5:0]          hit_x;

  assign start_acc = (state_q == StIdle) && bus.start;
  assign load_hs   = (state_q == StLoad) && bus.row_valid && row_ready_q;
  assign cur_row   = (row_q < 6'(NROW)) ? map_q[row_q] : '0;
  assign scan_hit  = (state_q == StScan) && (|cur_row);
  assign hit_mask  = {{(NCOL-1){1'b0}}, 1'b1} << hit_x;

  // Lowest set column of the current row.
  always_comb begin
    hit_x = '0;
    for (int i = NCOL - 1; i >= 0; i--) begin
      if (cur_row[i]) hit_x = 6'(i);
    end
  end

  // Any bit left in the map once the current hit is cleared.
  always_comb begin
    remain = |(cur_row & ~hit_mask);
    for (int unsigned i = 0; i < NROW; i++) begin
      if (6'(i) != row_q) remain = remain | (|map_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          row_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StLoad: begin
        if (load_hs && bus.row_last) state_d = StScan;
      end
      StScan: begin
        if (|cur_row) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_d == 9'(CAP)) begin
            state_d = StHdr;
            ovf_d   = remain;
          end
        end else begin
          row_d = row_q + 6'd1;
          if (row_d == 6'(NROW)) state_d = StHdr;
        end
      end
      StHdr: begin
        state_d = StData;
        slot_d  = '0;
      end
      StData: begin
        if (slot_q == SlotW'(NSLOT - 1)) state_d = StTrail;
        else                             slot_d  = slot_q + 1'b1;
      end
      StTrail: state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    fiber_d = '0;
    fxch_d  = '0;
    case (state_d)
      StHdr:   fiber_d = 16'hAAAA;
      StData: begin
        for (int unsigned n = 0; n < NLANE; n++) begin
          fxch_d[16*n +: 16] = {3'b000, buf_q[{slot_d, LaneW'(n)}]};
        end
      end
      StTrail: fiber_d = {6'b0, fid_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      slot_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      fid_q       <= '0;
      row_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fiber_q     <= '0;
      fxch_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      if (start_acc) fid_q <= bus.frame_id;
      row_ready_q <= (state_d == StLoad);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StTrail);
      fiber_q     <= fiber_d;
      fxch_q      <= fxch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      for (int unsigned i = 0; i < NROW; i++) map_q[i] <= '0;
    end else if (load_hs && (bus.row_y < 6'(NROW))) begin
      map_q[bus.row_y] <= map_q[bus.row_y] | bus.row_bits;
    end else if (scan_hit) begin
      map_q[row_q] <= cur_row & ~hit_mask;
    end
  end

  // Entry k sits at {slot, lane}; coordinates are stored minus one, mod 64.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      for (int unsigned k = 0; k < CAP; k++) buf_q[k] <= '0;
    end else if (scan_hit) begin
      buf_q[cnt_q[BufW-1:0]] <= {1'b1, hit_x - 6'd1, row_q - 6'd1};
    end
  end

  assign bus.row_ready = row_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fiber     = fiber_q;
  assign bus.fxch      = fxch_q;
  assign bus.overflow  = ovf_q;
  assign bus.hit_count = cnt_q;
endmodule

// File: tb/tb_hit_frame_encoder.sv
// Self-checking bench for hit_frame_encoder: scoreboard of expected lane words
// plus a receiver-style decoder rebuilding the bitmap from the fiber stream.
module tb_hit_frame_encoder;
  localparam int NROW  = 38;
  localparam int NCOL  = 38;
  localparam int NLANE = 16;
  localparam int NSLOT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failures = 0;
  int   cyc = 0;

  hit_frame_encoder_if #(.NCOL(NCOL), .NLANE(NLANE)) bus ();

  hit_frame_encoder #(.NROW(NROW), .NCOL(NCOL), .NLANE(NLANE), .NSLOT(NSLOT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]         exp_q [$];
  logic [NCOL-1:0]     mmap [NROW];
  logic [NCOL-1:0]     dec_map [NROW];
  logic [15:0]         cap_words [256];
  logic [16*NLANE-1:0] exp_vec;
  logic [15:0]         mw;
  int                  mdx, mdy;
  int                  exp_cnt;
  bit                  exp_ovf;
  int                  data_idx = -1;
  int                  hdr_cnt = 0;
  int                  last_hdr = 0;

  function automatic logic [15:0] enc(input int x, input int y);
    logic [5:0] xf, yf;
    xf = 6'((x + 63) % 64);
    yf = 6'((y + 63) % 64);
    return {3'b000, 1'b1, xf, yf};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: raster-scan the model map, cap at 256, pad with empty words.
  task automatic push_expected();
    int k = 0;
    for (int y = 0; y < NROW; y++) begin
      for (int x = 0; x < NCOL; x++) begin
        if (mmap[y][x]) begin
          if (k < 256) exp_q.push_back(enc(x, y));
          k++;
        end
      end
    end
    exp_cnt = (k > 256) ? 256 : k;
    exp_ovf = (k > 256);
    for (int i = exp_cnt; i < 256; i++) exp_q.push_back(16'h0000);
  endtask

  // Monitor: header spacing, data slots against the scoreboard, receiver decode.
  always begin
    @(posedge clk);
    #1;
    if (bus.busy !== 1'b1) begin
      data_idx = -1;
    end else if (bus.fiber === 16'hAAAA) begin
      if (hdr_cnt > 0) begin
        tests++;
        if (cyc - last_hdr < 19) begin
          failures++;
          $display("FAIL hdr_spacing: got %0d cycles, need >= 19", cyc - last_hdr);
        end
      end
      tests++;
      if (bus.fxch !== '0) begin
        failures++;
        $display("FAIL hdr_fxch: got %h, want 0", bus.fxch);
      end
      hdr_cnt++;
      last_hdr = cyc;
      data_idx = 0;
    end else if (data_idx >= 0 && data_idx < NSLOT) begin
      for (int n = 0; n < NLANE; n++) begin
        exp_vec[16*n +: 16] = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      end
      tests++;
      if (bus.fxch !== exp_vec || bus.fiber !== 16'h0000) begin
        failures++;
        $display("FAIL data_slot%0d: fiber=%h fxch=%h want fiber=0000 fxch=%h",
                 data_idx, bus.fiber, bus.fxch, exp_vec);
      end
      for (int n = 0; n < NLANE; n++) begin
        mw = bus.fxch[16*n +: 16];
        cap_words[data_idx*NLANE + n] = mw;
        if (mw[12] === 1'b1) begin
          mdx = (int'(mw[11:6]) + 1) % 64;
          mdy = (int'(mw[5:0]) + 1) % 64;
          if (mdx < NCOL && mdy < NROW) dec_map[mdy][mdx] = 1'b1;
        end
      end
      data_idx++;
    end
  end

  task automatic clear_maps();
    for (int y = 0; y < NROW; y++) begin
      mmap[y]    = '0;
      dec_map[y] = '0;
    end
  endtask

  task automatic start_frame(input logic [9:0] fid);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 1000) begin
      step();
      n++;
    end
    clear_maps();
    bus.frame_id = fid;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  task automatic send_row(input int y, input logic [NCOL-1:0] bits, input bit last);
    int n = 0;
    while (bus.row_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      tests++;
      failures++;
      $display("FAIL row_ready_timeout: row_ready=%b want 1", bus.row_ready);
    end
    bus.row_valid = 1'b1;
    bus.row_y     = 6'(y);
    bus.row_bits  = bits;
    bus.row_last  = last;
    step();
    bus.row_valid = 1'b0;
    bus.row_last  = 1'b0;
    if (y < NROW) mmap[y] = mmap[y] | bits;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    ok = (bus.done === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    tests++;
    if (bus.fiber !== 16'h0 || bus.fxch !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.row_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: fiber=%h busy=%b done=%b row_ready=%b want all 0",
               bus.fiber, bus.busy, bus.done, bus.row_ready);
    end
    tests++;
    if (bus.hit_count !== 9'd0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_counts: hit_count=%0d overflow=%b want 0/0", bus.hit_count, bus.overflow);
    end
    rst = 1'b0;
    step();
    tests++;
    if (bus.busy !== 1'b0 || bus.row_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b row_ready=%b want 0/0", bus.busy, bus.row_ready);
    end
  endtask

  task automatic test_single_hit();
    logic [NCOL-1:0] b;
    bit ok;
    b = '0;
    b[5] = 1'b1;
    start_frame(10'h155);
    send_row(20, b, 1'b1);
    push_expected();
    wait_done(ok);
    tests++;
    if (!ok) begin
      failures++;
      $display("FAIL single_done: no done pulse, want done=1");
    end
    tests++;
    if (bus.fiber !== 16'h0155 || bus.hit_count !== 9'd1 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL single_trailer: fiber=%h count=%0d ovf=%b want 0155/1/0",
               bus.fiber, bus.hit_count, bus.overflow);
    end
    tests++;
    if (cap_words[0] !== enc(5, 20)) begin
      failures++;
      $display("FAIL single_word: got %h want %h", cap_words[0], enc(5, 20));
    end
  endtask

  task automatic test_ordering();
    logic [NCOL-1:0] b;
    bit ok;
    start_frame(10'h001);
    b = '0;
    b[3] = 1'b1;
    b[1] = 1'b1;
    send_row(4, b, 1'b0);
    b = '0;
    b[0] = 1'b1;
    send_row(0, b, 1'b1);
    push_expected();
    wait_done(ok);
    tests++;
    if (!ok || bus.hit_count !== 9'd3) begin
      failures++;
      $display("FAIL order_count: done=%b count=%0d want 1/3", bus.done, bus.hit_count);
    end
    tests++;
    if (cap_words[0] !== 16'h1FFF || cap_words[1] !== 16'h1003 || cap_words[2] !== 16'h1083) begin
      failures++;
      $display("FAIL order_words: got %h %h %h want 1fff 1003 1083",
               cap_words[0], cap_words[1], cap_words[2]);
    end
  endtask

  task automatic test_capacity();
    int c = 0;
    bit ok;
    start_frame(10'h2A5);
    for (int y = 0; y < NROW; y++) send_row(y, '1, y == NROW - 1);
    push_expected();
    wait_done(ok);
    tests++;
    if (!ok || bus.hit_count !== 9'd256 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL cap_full: done=%b count=%0d ovf=%b want 1/256/1",
               bus.done, bus.hit_count, bus.overflow);
    end
    for (int k = 0; k < 256; k++) c += int'(cap_words[k][12]);
    tests++;
    if (c != 256 || cap_words[255] !== 16'h1685) begin
      failures++;
      $display("FAIL cap_words: valid=%0d last=%h want 256/1685", c, cap_words[255]);
    end
    step();
    step();
    tests++;
    if (bus.busy !== 1'b0 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_hold: busy=%b ovf=%b want 0/1", bus.busy, bus.overflow);
    end
    start_frame(10'h2A6);
    tests++;
    if (bus.overflow !== 1'b0 || bus.hit_count !== 9'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL ovf_clear_on_start: ovf=%b count=%0d busy=%b want 0/0/1",
               bus.overflow, bus.hit_count, bus.busy);
    end
    for (int y = 0; y < 6; y++) send_row(y, '1, 1'b0);
    send_row(6, 38'h00_0FFF_FFFF, 1'b1);
    push_expected();
    wait_done(ok);
    tests++;
    if (!ok || bus.hit_count !== 9'd256 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL cap_exact: done=%b count=%0d ovf=%b want 1/256/0",
               bus.done, bus.hit_count, bus.overflow);
    end
  endtask

  task automatic test_handshake();
    logic [NCOL-1:0] b;
    int n = 0;
    int busy_low = 0;
    int rr_high = 0;
    bit ok;
    while (bus.busy !== 1'b0 && n < 1000) begin
      step();
      n++;
    end
    tests++;
    if (bus.row_ready !== 1'b0) begin
      failures++;
      $display("FAIL row_ready_idle: got %b want 0", bus.row_ready);
    end
    start_frame(10'h0C3);
    b = '0;
    b[0] = 1'b1;
    send_row(22, b, 1'b0);
    b = '0;
    b[3] = 1'b1;
    send_row(40, b, 1'b0);
    b = '0;
    b[37] = 1'b1;
    send_row(22, b, 1'b1);
    push_expected();
    n = 0;
    while (bus.fiber !== 16'hAAAA && n < 500) begin
      step();
      n++;
    end
    step();
    step();
    bus.frame_id = 10'h3FF;
    bus.start    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.row_ready !== 1'b0) rr_high++;
      step();
    end
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.row_ready !== 1'b0) rr_high++;
      step();
      n++;
    end
    ok = (bus.done === 1'b1);
    tests++;
    if (!ok || busy_low != 0 || rr_high != 0) begin
      failures++;
      $display("FAIL hs_busy: done=%b busy_low=%0d row_ready_high=%0d want 1/0/0",
               bus.done, busy_low, rr_high);
    end
    tests++;
    if (bus.fiber !== 16'h00C3 || bus.hit_count !== 9'd2) begin
      failures++;
      $display("FAIL hs_trailer: fiber=%h count=%0d want 00c3/2", bus.fiber, bus.hit_count);
    end
    tests++;
    if (dec_map[22] !== 38'h20_0000_0001) begin
      failures++;
      $display("FAIL hs_merge: row22=%h want 2000000001", dec_map[22]);
    end
    step();
    step();
    tests++;
    if (bus.busy !== 1'b0 || bus.row_ready !== 1'b0) begin
      failures++;
      $display("FAIL hs_start_ignored: busy=%b row_ready=%b want 0/0", bus.busy, bus.row_ready);
    end
  endtask

  task automatic test_reset_mid_data();
    logic [NCOL-1:0] b;
    int n = 0;
    bit ok;
    start_frame(10'h111);
    send_row(0, '1, 1'b0);
    b = '0;
    b[0] = 1'b1;
    b[1] = 1'b1;
    send_row(1, b, 1'b1);
    push_expected();
    while (bus.fiber !== 16'hAAAA && n < 500) begin
      step();
      n++;
    end
    repeat (8) step();
    rst = 1'b1;
    step();
    tests++;
    if (bus.fiber !== 16'h0 || bus.fxch !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs: fiber=%h busy=%b done=%b want 0/0/0",
               bus.fiber, bus.busy, bus.done);
    end
    rst = 1'b0;
    exp_q.delete();
    step();
    b = '0;
    b[37] = 1'b1;
    start_frame(10'h222);
    send_row(37, b, 1'b1);
    push_expected();
    wait_done(ok);
    tests++;
    if (!ok || bus.fiber !== 16'h0222 || bus.hit_count !== 9'd1 || cap_words[0] !== enc(37, 37)) begin
      failures++;
      $display("FAIL abort_recover: fiber=%h count=%0d word=%h want 0222/1/%h",
               bus.fiber, bus.hit_count, cap_words[0], enc(37, 37));
    end
    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_drain: %0d expected words left, want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [NCOL-1:0] b;
    int n = 0;
    int bad;
    int h0;
    bit ok;
    while (bus.busy !== 1'b0 && n < 1000) begin
      step();
      n++;
    end
    h0 = hdr_cnt;
    clear_maps();
    bus.frame_id = 10'h0A1;
    bus.start    = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int y = 0; y < NROW; y++) begin
        b = '0;
        if (f == 0 && $urandom_range(0, 3) == 0) b[$urandom_range(0, NCOL - 1)] = 1'b1;
        if (f == 1) begin
          b[$urandom_range(0, NCOL - 1)] = 1'b1;
          b[$urandom_range(0, NCOL - 1)] = 1'b1;
        end
        send_row(y, b, y == NROW - 1);
      end
      push_expected();
      wait_done(ok);
      if (f == 1) bus.start = 1'b0;
      tests++;
      if (!ok || bus.fiber !== ((f == 0) ? 16'h00A1 : 16'h00B2)) begin
        failures++;
        $display("FAIL b2b_trailer%0d: done=%b fiber=%h", f, bus.done, bus.fiber);
      end
      bad = 0;
      for (int y = 0; y < NROW; y++) if (dec_map[y] !== mmap[y]) bad++;
      tests++;
      if (bad != 0) begin
        failures++;
        $display("FAIL b2b_decode%0d: %0d rows differ, want 0", f, bad);
      end
      bus.frame_id = 10'h0B2;
      clear_maps();
    end
    tests++;
    if (hdr_cnt - h0 != 2) begin
      failures++;
      $display("FAIL b2b_headers: got %0d headers want 2", hdr_cnt - h0);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.frame_id  = '0;
    bus.row_valid = 1'b0;
    bus.row_y     = '0;
    bus.row_bits  = '0;
    bus.row_last  = 1'b0;
    clear_maps();
    test_reset();
    test_single_hit();
    test_ordering();
    test_capacity();
    test_handshake();
    test_reset_mid_data();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failures);
    $fatal(1);
  end
endmodule
